// File: rtl/burst_data_mem.sv
// Synchronous main-memory model serving whole cache blocks as fixed-length bursts after a programmable latency.
// Optional macro CRIT_WORD_FIRST_EN: start the burst at the requested word offset and wrap within the block.
module burst_data_mem #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 10,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int LATENCY         = 2,
  localparam int OFF_W          = $clog2(WORDS_PER_BLOCK),
  localparam int BASE_W         = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              beat_valid,
  output logic [OFF_W-1:0]  beat_idx,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  localparam logic [3:0]       LAT_LAST  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_BLOCK - 1);

  state_t            state, nxt_state;
  logic [3:0]        cnt, nxt_cnt;
  logic [OFF_W-1:0]  bcnt, nxt_bcnt;
  logic [OFF_W-1:0]  idx, nxt_idx;
  logic [BASE_W-1:0] base, nxt_base;
  logic              we, nxt_we;
  logic [OFF_W-1:0]  start_off;
  logic              accept;

  logic [DATA_W-1:0] ram [2**ADDR_W];

`ifdef CRIT_WORD_FIRST_EN
  assign start_off = req_addr[OFF_W-1:0];
`else
  // Offset bits are deliberately discarded: bursts always begin at word 0.
  assign start_off = req_addr[OFF_W-1:0] & '0;
`endif

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      bcnt  <= '0;
      idx   <= '0;
      base  <= '0;
      we    <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      bcnt  <= nxt_bcnt;
      idx   <= nxt_idx;
      base  <= nxt_base;
      we    <= nxt_we;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_bcnt  = bcnt;
    nxt_idx   = idx;
    nxt_base  = base;
    nxt_we    = we;
    case (state)
      S_IDLE: begin
        if (accept) begin
          nxt_base  = req_addr[ADDR_W-1:OFF_W];
          nxt_we    = req_we;
          nxt_idx   = start_off;
          nxt_bcnt  = '0;
          nxt_cnt   = '0;
          nxt_state = (LATENCY > 0) ? S_WAIT : S_BURST;
        end
      end
      S_WAIT: begin
        if (cnt == LAT_LAST) begin
          nxt_cnt   = '0;
          nxt_state = S_BURST;
        end else begin
          nxt_cnt = cnt + 4'd1;
        end
      end
      S_BURST: begin
        // Offset wraps naturally in OFF_W bits; the block base never moves.
        nxt_idx  = idx + OFF_W'(1);
        nxt_bcnt = bcnt + OFF_W'(1);
        if (bcnt == LAST_BEAT) begin
          nxt_idx   = '0;
          nxt_bcnt  = '0;
          nxt_state = S_IDLE;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    beat_valid = (state == S_BURST);
    beat_idx   = beat_valid ? idx : '0;
    done       = beat_valid && (bcnt == LAST_BEAT);
  end

  // Read data is fetched on the edge that starts each beat so it lines up with beat_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (nxt_state == S_BURST && !nxt_we) begin
      rd_data <= ram[{nxt_base, nxt_idx}];
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_BURST && we) begin
      ram[{base, idx}] <= wr_data;
    end
  end

endmodule

// File: tb/tb_burst_data_mem.sv
// Randomized self-checking bench for burst_data_mem: default instance plus a zero-latency 8-word instance.
module tb_burst_data_mem;

  localparam int W  = 4;
  localparam int L  = 2;
  localparam int WB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] wr_data = '0, rd_data;
  logic        req_ready, beat_valid, done;
  logic [1:0]  beat_idx;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [9:0]  b_req_addr = '0;
  logic [31:0] b_wr_data = '0, b_rd_data;
  logic        b_req_ready, b_beat_valid, b_done;
  logic [2:0]  b_beat_idx;

  int checks = 0;
  int passed = 0;

  logic [31:0] mem [1024];
  bit          known [1024];
  logic [31:0] beat_data [W];
  logic [31:0] bmem [WB];

  always #5 clk = ~clk;

  burst_data_mem #(.DATA_W(32), .ADDR_W(10), .WORDS_PER_BLOCK(W), .LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .wr_data(wr_data), .rd_data(rd_data), .beat_valid(beat_valid),
    .beat_idx(beat_idx), .done(done)
  );

  burst_data_mem #(.DATA_W(32), .ADDR_W(10), .WORDS_PER_BLOCK(WB), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .wr_data(b_wr_data), .rd_data(b_rd_data), .beat_valid(b_beat_valid),
    .beat_idx(b_beat_idx), .done(b_done)
  );

  // Beat order as defined by the burst rules: plain 0..W-1, or wrapping from the requested offset.
  function automatic int exp_idx(input int addr, input int k);
`ifdef CRIT_WORD_FIRST_EN
    return ((addr % W) + k) % W;
`else
    return k;
`endif
  endfunction

  // Issue one burst on the default instance at a negedge; returns at a negedge.
  task automatic burst(input bit we, input int addr, input bit hold, input int abort_at);
    int lat, ix, a;
    logic [31:0] last;
    last = '0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = 10'(addr);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL ready_before_accept addr=%0h got=%b exp=1", addr, req_ready);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    lat = 1;
    while (beat_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != L + 1) $display("FAIL first_beat_latency addr=%0h got=%0d exp=%0d", addr, lat, L + 1);
    else passed++;
    for (int k = 0; k < W; k++) begin
      ix = exp_idx(addr, k);
      a  = (addr / W) * W + ix;
      checks++;
      if ({beat_valid, beat_idx, done, req_ready} !== {1'b1, 2'(ix), (k == W - 1), 1'b0})
        $display("FAIL beat%0d_ctrl addr=%0h got v=%b idx=%0d done=%b rdy=%b exp v=1 idx=%0d done=%b rdy=0",
                 k, addr, beat_valid, beat_idx, done, req_ready, ix, (k == W - 1));
      else passed++;
      if (!we && known[a]) begin
        last = mem[a];
        checks++;
        if (rd_data !== mem[a]) $display("FAIL beat%0d_rd_data addr=%0h got=%h exp=%h", k, a, rd_data, mem[a]);
        else passed++;
      end
      if (we) wr_data = beat_data[k];
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, beat_valid, beat_idx, done, rd_data} !== {1'b1, 1'b0, 2'd0, 1'b0, 32'd0})
          $display("FAIL reset_mid_burst got rdy=%b v=%b idx=%0d done=%b rd=%h exp rdy=1 v=0 idx=0 done=0 rd=0",
                   req_ready, beat_valid, beat_idx, done, rd_data);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (we) begin
        mem[a]   = beat_data[k];
        known[a] = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if ({beat_valid, done, req_ready} !== 3'b001)
      $display("FAIL after_burst addr=%0h got v=%b done=%b rdy=%b exp v=0 done=0 rdy=1", addr, beat_valid, done, req_ready);
    else passed++;
    if (!we && known[(addr / W) * W + exp_idx(addr, W - 1)]) begin
      checks++;
      if (rd_data !== last) $display("FAIL rd_data_hold addr=%0h got=%h exp=%h", addr, rd_data, last);
      else passed++;
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < W; k++) beat_data[k] = $urandom;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, beat_valid, beat_idx, done, rd_data} !== {1'b1, 1'b0, 2'd0, 1'b0, 32'd0})
      $display("FAIL reset_state got rdy=%b v=%b idx=%0d done=%b rd=%h exp rdy=1 v=0 idx=0 done=0 rd=0",
               req_ready, beat_valid, beat_idx, done, rd_data);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, beat_valid, done, b_req_ready, b_beat_valid} !== 5'b10010)
      $display("FAIL post_reset_idle got rdy=%b v=%b done=%b b_rdy=%b b_v=%b exp 1 0 0 1 0",
               req_ready, beat_valid, done, b_req_ready, b_beat_valid);
    else passed++;
  endtask

  task automatic test_read_default();
    rand_data();
    burst(1'b1, 8, 1'b0, -1);
    burst(1'b0, 9, 1'b0, -1);
    burst(1'b0, 10, 1'b0, -1);
  endtask

  task automatic test_write_readback();
    beat_data[0] = 32'h11; beat_data[1] = 32'h22; beat_data[2] = 32'h33; beat_data[3] = 32'h44;
    burst(1'b1, 'h40, 1'b0, -1);
    burst(1'b0, 'h40, 1'b0, -1);
  endtask

  task automatic test_random();
    int addr;
    for (int b = 0; b < 8; b++) begin
      rand_data();
      burst(1'b1, 'h100 + b * W + int'($urandom_range(0, W - 1)), 1'b0, -1);
    end
    for (int n = 0; n < 20; n++) begin
      addr = 'h100 + int'($urandom_range(0, 8 * W - 1));
      rand_data();
      burst(1'($urandom_range(0, 1)), addr, 1'b0, -1);
    end
  endtask

  task automatic test_reset_mid_write();
    rand_data();
    burst(1'b1, 'h20, 1'b0, -1);
    rand_data();
    burst(1'b1, 'h20, 1'b0, 2);
    burst(1'b0, 'h20, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    burst(1'b0, 'h40, 1'b1, -1);
    burst(1'b0, 'h102, 1'b1, -1);
    burst(1'b0, 'h9, 1'b0, -1);
  endtask

  task automatic test_lat0();
    for (int pass = 0; pass < 2; pass++) begin
      b_req_valid = 1'b1;
      b_req_we    = (pass == 0);
      b_req_addr  = '0;
      checks++;
      if (b_req_ready !== 1'b1) $display("FAIL lat0_ready pass=%0d got=%b exp=1", pass, b_req_ready);
      else passed++;
      @(posedge clk);
      @(negedge clk);
      b_req_valid = 1'b0;
      for (int k = 0; k < WB; k++) begin
        checks++;
        if ({b_beat_valid, b_beat_idx, b_done} !== {1'b1, 3'(k), (k == WB - 1)})
          $display("FAIL lat0_beat%0d pass=%0d got v=%b idx=%0d done=%b exp v=1 idx=%0d done=%b",
                   k, pass, b_beat_valid, b_beat_idx, b_done, k, (k == WB - 1));
        else passed++;
        if (pass == 0) begin
          bmem[k]   = $urandom;
          b_wr_data = bmem[k];
        end else begin
          checks++;
          if (b_rd_data !== bmem[k]) $display("FAIL lat0_rd%0d got=%h exp=%h", k, b_rd_data, bmem[k]);
          else passed++;
        end
        @(negedge clk);
      end
      checks++;
      if ({b_beat_valid, b_req_ready} !== 2'b01)
        $display("FAIL lat0_end pass=%0d got v=%b rdy=%b exp v=0 rdy=1", pass, b_beat_valid, b_req_ready);
      else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) known[i] = 1'b0;
    test_reset();
    test_read_default();
    test_write_readback();
    test_random();
    test_reset_mid_write();
    test_back_to_back();
    test_lat0();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
